iq_integrate_dump: RTL and testbench

- Consumer for the mixer's interleaved complex sample stream. Input is one I word followed by one Q word; the Q word is marked by last_i=1.
- Pairs the I and Q words, resynchronises when a last marker is missing or extra, and runs an integrate-and-dump decimator over DECIM pairs.
- Emits one parallel I/Q result per DECIM input pairs on a valid/ready output.
- Sits between the mixer and the downstream filter/magnitude chain in the receiver path.

---
 rtl/rx_pkg.sv | 19 +
 rtl/iq_integrate_dump_if.sv | 28 ++
 rtl/iq_integrate_dump.sv | 113 +++++++++++
 tb/tb_iq_integrate_dump.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared receiver-path definitions: the mixer stream beat and the sizing helper
// used by the I/Q consumers.
package rx_pkg;

  localparam int RX_DW = 16;

  // One beat of the mixer's interleaved I/Q stream; last marks the Q word.
  typedef struct packed {
    logic signed [RX_DW-1:0] data;
    logic                    valid;
    logic                    last;
  } rx_beat_t;

  // Counter width for n states, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iq_integrate_dump_if.sv
// Input stream plus integrated I/Q output of the integrate-and-dump stage.
// slave is the block side, master is the driving/consuming environment.
interface iq_integrate_dump_if #(
  parameter int DW    = 16,
  parameter int DECIM = 64
);
  localparam int OW = DW + $clog2(DECIM);

  logic signed [DW-1:0] data_i;
  logic                 valid_i;
  logic                 last_i;
  logic                 ready_o;
  logic signed [OW-1:0] i_o;
  logic signed [OW-1:0] q_o;
  logic                 valid_o;
  logic                 ready_i;
  logic                 sync_err_o;

  modport slave (
    input  data_i, valid_i, last_i, ready_i,
    output ready_o, i_o, q_o, valid_o, sync_err_o
  );

  modport master (
    output data_i, valid_i, last_i, ready_i,
    input  ready_o, i_o, q_o, valid_o, sync_err_o
  );
endinterface

// File: rtl/iq_integrate_dump.sv
// Pairs interleaved I/Q words, recovers from missing or extra last markers and
// sums DECIM pairs into one full-precision I/Q result on a valid/ready output.
module iq_integrate_dump
  import rx_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DECIM = 64
) (
  input logic                clk,
  input logic                rst,
  iq_integrate_dump_if.slave bus
);

  localparam int OW = DW + $clog2(DECIM);
  localparam int CW = clog2_min1(DECIM);
  localparam logic [CW-1:0] LAST_CNT = CW'(DECIM - 1);

  typedef enum logic {
    WAIT_I = 1'b0,
    WAIT_Q = 1'b1
  } state_t;

  state_t               state, state_nxt;
  logic signed [DW-1:0] i_hold;
  logic signed [OW-1:0] acc_i, acc_q;
  logic signed [OW-1:0] i_r, q_r;
  logic [CW-1:0]        pair_cnt;
  logic                 valid_r, sync_err_r;
  logic                 ready, accept, load_i, pair_done, dump, frame_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_I;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path leaves state_nxt unassigned
    // and no latch is inferred.
    state_nxt = state;
    if (accept) begin
      unique case (state)
        WAIT_I:  if (!bus.last_i) state_nxt = WAIT_Q;
        WAIT_Q:  if (bus.last_i)  state_nxt = WAIT_I;
        default: state_nxt = WAIT_I;
      endcase
    end
  end

  // Stall only when this pair would dump while the output slot is still full;
  // depends on registered state alone, never on ready_i.
  always_comb begin
    ready     = !(state == WAIT_Q && pair_cnt == LAST_CNT && valid_r);
    accept    = bus.valid_i && ready;
    load_i    = accept && !bus.last_i;
    pair_done = accept && bus.last_i && (state == WAIT_Q);
    dump      = pair_done && (pair_cnt == LAST_CNT);
    frame_err = accept && ((state == WAIT_I && bus.last_i) ||
                           (state == WAIT_Q && !bus.last_i));
  end

  // A second I without its Q simply replaces the held word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         i_hold <= '0;
    else if (load_i) i_hold <= bus.data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc_i <= '0;
    else if (dump)      acc_i <= '0;
    else if (pair_done) acc_i <= acc_i + OW'(i_hold);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            acc_q <= '0;
    else if (dump)      acc_q <= '0;
    else if (pair_done) acc_q <= acc_q + OW'(bus.data_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            pair_cnt <= '0;
    else if (dump)      pair_cnt <= '0;
    else if (pair_done) pair_cnt <= pair_cnt + CW'(1);
  end

  // A fresh dump wins over the handshake so back-to-back results are not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_r     <= '0;
      q_r     <= '0;
      valid_r <= 1'b0;
    end else if (dump) begin
      i_r     <= acc_i + OW'(i_hold);
      q_r     <= acc_q + OW'(bus.data_i);
      valid_r <= 1'b1;
    end else if (valid_r && bus.ready_i) begin
      valid_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_err_r <= 1'b0;
    else     sync_err_r <= frame_err;
  end

  assign bus.ready_o    = ready;
  assign bus.i_o        = i_r;
  assign bus.q_o        = q_r;
  assign bus.valid_o    = valid_r;
  assign bus.sync_err_o = sync_err_r;

endmodule

// File: tb/tb_iq_integrate_dump.sv
// Directed and random stimulus for iq_integrate_dump (DECIM=4 and DECIM=1),
// scored against a pair-and-sum model of the stream.
module tb_iq_integrate_dump;
  import rx_pkg::*;

  localparam int DW    = 16;
  localparam int DECIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  iq_integrate_dump_if #(.DW(DW), .DECIM(DECIM)) bus ();
  iq_integrate_dump_if #(.DW(DW), .DECIM(1))     bus1 ();

  iq_integrate_dump #(.DW(DW), .DECIM(DECIM)) dut  (.clk(clk), .rst(rst), .bus(bus));
  iq_integrate_dump #(.DW(DW), .DECIM(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // The DECIM=1 instance sees exactly the beats the main instance accepts.
  logic rdy_fixed = 1'b1, rnd_rdy = 1'b1, rand_ready = 1'b0;
  assign bus.ready_i   = rand_ready ? rnd_rdy : rdy_fixed;
  assign bus1.data_i   = bus.data_i;
  assign bus1.last_i   = bus.last_i;
  assign bus1.valid_i  = bus.valid_i && bus.ready_o;
  assign bus1.ready_i  = 1'b1;

  int tests = 0, fails = 0;
  int cyc = 0, last_acc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rand_ready) begin
    #2 rnd_rdy = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int got_i[$], got_q[$], got_cyc[$], got1_i[$], got1_q[$];
  int err_cnt = 0, err1_cnt = 0, vh_cnt = 0;
  bit saw_stall = 0, hold_prev = 0;
  logic signed [31:0] prev_i, prev_q;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 0;
    end else begin
      if (bus.valid_o && bus.ready_i) begin
        got_i.push_back(32'(bus.i_o));
        got_q.push_back(32'(bus.q_o));
        got_cyc.push_back(cyc);
      end
      if (bus.valid_o)    vh_cnt++;
      if (bus.sync_err_o) err_cnt++;
      if (bus1.valid_o) begin
        got1_i.push_back(32'(bus1.i_o));
        got1_q.push_back(32'(bus1.q_o));
      end
      if (bus1.sync_err_o) err1_cnt++;
      if (bus.valid_i && !bus.ready_o) saw_stall = 1;
      if (hold_prev) begin
        check("hold_valid", 32'(bus.valid_o), 1);
        check("hold_i", 32'(bus.i_o), prev_i);
        check("hold_q", 32'(bus.q_o), prev_q);
      end
      hold_prev = bus.valid_o && !bus.ready_i;
      prev_i    = 32'(bus.i_o);
      prev_q    = 32'(bus.q_o);
    end
  end

  // ---------------- reference model ----------------
  // Pairs words by the last flag, counts framing slips, and sums groups.
  int  exp_i[$], exp_q[$], exp1_i[$], exp1_q[$];
  int  exp_err = 0, m_held = 0, m_sum_i = 0, m_sum_q = 0, m_pairs = 0;
  bit  m_have = 0;

  task automatic model_reset();
    m_have = 0; m_held = 0; m_sum_i = 0; m_sum_q = 0; m_pairs = 0;
  endtask

  task automatic model_beat(input int d, input bit l);
    if (!l) begin
      if (m_have) exp_err++;
      m_held = d;
      m_have = 1;
    end else if (!m_have) begin
      exp_err++;
    end else begin
      m_have = 0;
      exp1_i.push_back(m_held);
      exp1_q.push_back(d);
      m_sum_i += m_held;
      m_sum_q += d;
      m_pairs++;
      if (m_pairs == DECIM) begin
        exp_i.push_back(m_sum_i);
        exp_q.push_back(m_sum_q);
        m_sum_i = 0; m_sum_q = 0; m_pairs = 0;
      end
    end
  endtask

  // ---------------- stimulus helpers ----------------
  // Called at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input int d, input bit l);
    rx_beat_t b;
    int n = 0;
    b.data = 16'(d); b.valid = 1'b1; b.last = l;
    bus.data_i = b.data; bus.valid_i = b.valid; bus.last_i = b.last;
    @(negedge clk);
    while (!bus.ready_o && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (n >= 60) check("accept_timeout", 32'(bus.ready_o), 1);
    last_acc = cyc;
    model_beat(int'(b.data), l);
    @(posedge clk); #2;
  endtask

  task automatic pair(input int i, input int q);
    send(i, 1'b0);
    send(q, 1'b1);
  endtask

  task automatic idle(input int n);
    bus.valid_i = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got_i.size() < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("drain_count", got_i.size(), n);
    @(posedge clk); #2;
  endtask

  int err0, err10, exp_err0, vh0;

  task automatic phase_start();
    err0 = err_cnt; err10 = err1_cnt; exp_err0 = exp_err; vh0 = vh_cnt;
    saw_stall = 0;
  endtask

  task automatic phase_end(input string tag);
    check({tag, "_nout"}, got_i.size(), exp_i.size());
    for (int k = 0; k < got_i.size() && k < exp_i.size(); k++) begin
      check({tag, "_i"}, got_i[k], exp_i[k]);
      check({tag, "_q"}, got_q[k], exp_q[k]);
    end
    check({tag, "_d1_nout"}, got1_i.size(), exp1_i.size());
    for (int k = 0; k < got1_i.size() && k < exp1_i.size(); k++) begin
      check({tag, "_d1_i"}, got1_i[k], exp1_i[k]);
      check({tag, "_d1_q"}, got1_q[k], exp1_q[k]);
    end
    check({tag, "_err"}, err_cnt - err0, exp_err - exp_err0);
    check({tag, "_d1_err"}, err1_cnt - err10, exp_err - exp_err0);
    got_i.delete(); got_q.delete(); got_cyc.delete(); got1_i.delete(); got1_q.delete();
    exp_i.delete(); exp_q.delete(); exp1_i.delete(); exp1_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    bus.data_i = '0; bus.valid_i = 1'b0; bus.last_i = 1'b0;
    model_reset();

    // Reset values
    @(negedge clk);
    check("rst_i_o", 32'(bus.i_o), 0);
    check("rst_q_o", 32'(bus.q_o), 0);
    check("rst_valid_o", 32'(bus.valid_o), 0);
    check("rst_sync_err", 32'(bus.sync_err_o), 0);
    check("rst_ready_o", 32'(bus.ready_o), 1);
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;

    // Normal stream: latency one cycle, valid_o for exactly one cycle
    phase_start();
    pair(100, -50); pair(200, -50); pair(300, -50); pair(-100, -50);
    idle(6);
    drain(1);
    if (got_i.size() > 0) begin
      check("t1_i", got_i[0], 500);
      check("t1_q", got_q[0], -200);
      check("t1_latency", got_cyc[0], last_acc + 1);
    end
    check("t1_valid_cycles", vh_cnt - vh0, 1);
    check("t1_no_err", err_cnt - err0, 0);
    if (got1_i.size() > 0) begin
      check("t1_d1_i0", got1_i[0], 100);
      check("t1_d1_q0", got1_q[0], -50);
    end
    phase_end("t1");

    // Extremes: full-precision sums without wrap
    phase_start();
    for (int k = 0; k < 4; k++) pair(-32768, 32767);
    idle(4);
    drain(1);
    if (got_i.size() > 0) begin
      check("t2_i", got_i[0], -131072);
      check("t2_q", got_q[0], 131068);
    end
    phase_end("t2");

    // Orphan Q is discarded
    phase_start();
    send(5, 1'b1);
    for (int k = 0; k < 4; k++) pair(1, 2);
    idle(4);
    drain(1);
    if (got_i.size() > 0) begin
      check("t3_i", got_i[0], 4);
      check("t3_q", got_q[0], 8);
    end
    check("t3_err", err_cnt - err0, 1);
    phase_end("t3");

    // Missing Q: second I replaces the first
    phase_start();
    send(7, 1'b0); send(9, 1'b0); send(3, 1'b1);
    for (int k = 0; k < 3; k++) pair(1, 1);
    idle(4);
    drain(1);
    if (got_i.size() > 0) begin
      check("t4_i", got_i[0], 12);
      check("t4_q", got_q[0], 6);
    end
    check("t4_err", err_cnt - err0, 1);
    phase_end("t4");

    // Backpressure: output slot full, eighth Q must stall until ready_i
    phase_start();
    rdy_fixed = 1'b0;
    fork
      begin
        for (int k = 0; k < 8; k++) pair(1, 1);
      end
      begin
        repeat (30) @(posedge clk);
        #2 rdy_fixed = 1'b1;
      end
    join
    idle(4);
    drain(2);
    check("t5_stall_seen", 32'(saw_stall), 1);
    if (got_i.size() > 1) begin
      check("t5_i0", got_i[0], 4);
      check("t5_q0", got_q[0], 4);
      check("t5_i1", got_i[1], 4);
      check("t5_q1", got_q[1], 4);
    end
    phase_end("t5");

    // Asynchronous reset mid-accumulation, with an I word held
    phase_start();
    pair(1, 1); pair(1, 1); send(50, 1'b0);
    bus.valid_i = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    check("t6_rst_i_o", 32'(bus.i_o), 0);
    check("t6_rst_q_o", 32'(bus.q_o), 0);
    check("t6_rst_valid_o", 32'(bus.valid_o), 0);
    check("t6_rst_sync_err", 32'(bus.sync_err_o), 0);
    check("t6_rst_d1_i_o", 32'(bus1.i_o), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) pair(1, 1);
    idle(4);
    drain(1);
    if (got_i.size() > 0) begin
      check("t6_i", got_i[0], 4);
      check("t6_q", got_q[0], 4);
    end
    check("t6_err", err_cnt - err0, 0);
    phase_end("t6");

    // Random data, occasional framing slips, gaps and random ready_i
    phase_start();
    rand_ready = 1'b1;
    begin
      bit lst = 1'b1;
      bit nl;
      for (int k = 0; k < 300; k++) begin
        nl = !lst;
        if ($urandom_range(0, 15) == 0) nl = lst;
        send(int'($urandom_range(0, 65535)) - 32768, nl);
        lst = nl;
        if ($urandom_range(0, 7) == 0) idle(1);
      end
    end
    idle(2);
    rand_ready = 1'b0;
    rdy_fixed  = 1'b1;
    idle(4);
    drain(exp_i.size());
    phase_end("t7");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
